fir_sequencer_param: RTL and testbench
======================================

Name: fir_sequencer_param

Overview:
Parametrised FIR sequencer that drives the shared register-file/ALU datapath through coefficient loading and per-sample multiply-accumulate passes. It generalises the fixed 4-tap controller to NTAPS taps with a per-tap add/subtract sign mask. It adds a coefficient-ready interlock and a single sticky error state. It sits between the input handshake logic (dr, lc) and the datapath (op/src/dest), and reports modwait, err and processed upstream.

Parameters:
NTAPS, 4, number of filter taps; legal range 2..8
REG_W, 4, register-index width; 2*NTAPS+2 <= 2**REG_W
SIGN_MASK, 4'b0101 (NTAPS bits), bit t=1 -> product of tap t subtracted, 0 -> added

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
dr  in  1  new sample ready
lc  in  1  load coefficient strobe
overflow  in  1  datapath ALU overflow flag, combinational from current op
cnt_up  out  1  one-cycle sample-count pulse to counter
clear  out  1  one-cycle counter clear pulse
modwait  out  1  registered busy flag
op  out  3  datapath opcode: NOP 000, COPY 001, LOAD_SAMPLE 010, LOAD_COEFF 011, ADD 100, SUB 101, MUL 110
src1  out  REG_W  source register A
src2  out  REG_W  source register B
dest  out  REG_W  destination register
err  out  1  error flag
processed  out  1  registered one-cycle result/abort pulse
coeff_ready  out  1  registered; all NTAPS coefficients loaded

Behaviour:
- Register map: R0 is the accumulator. R1..RNTAPS hold sample history (R1 oldest, RNTAPS newest). R(NTAPS+1+t) holds coefficient Ft. S = R(2*NTAPS+1) is scratch/new sample.
- Reset: state IDLE, tap counter 0, modwait=0, processed=0, coeff_ready=0. Combinational outputs default to 0: op=NOP, src/dest=0, cnt_up, clear, err.
- modwait <= 1 iff next state is LOAD, STORE, ZERO, SHIFT, MUL or ACC. It is therefore high exactly during those states.
- IDLE:
  - lc -> LOAD with k=0; lc wins if lc and dr are both high.
  - Otherwise dr & coeff_ready -> STORE.
  - dr & !coeff_ready -> ERR.
- LOAD(k): op=LOAD_COEFF, dest=R(NTAPS+1+k). clear=1 and coeff_ready<=0 only when k=0.
  - k<NTAPS-1 -> WAIT_COEFF.
  - k=NTAPS-1 -> IDLE with coeff_ready<=1.
- WAIT_COEFF: lc -> LOAD(k+1). dr is ignored. Otherwise stay.
- STORE: dr still high -> op=LOAD_SAMPLE, dest=S, cnt_up=1 -> ZERO. dr low -> ERR.
- ZERO: op=SUB, src1=src2=dest=R0 -> SHIFT with k=0.
- SHIFT(k): op=COPY.
  - k<NTAPS-1: dest=R(k+1), src1=R(k+2).
  - k=NTAPS-1: dest=RNTAPS, src1=S, then -> MUL with t=0.
- MUL(t): op=MUL, src1=R(NTAPS-t), src2=R(NTAPS+1+t), dest=S -> ACC(t).
- ACC(t): op = SUB if SIGN_MASK[t] else ADD; src1=R0, src2=S, dest=R0.
  - overflow=1 -> ERR with processed<=1.
  - Else t<NTAPS-1 -> MUL(t+1).
  - Else -> DONE with processed<=1.
- DONE: op=NOP -> IDLE.
- Latency: processed is high in the single cycle 3*NTAPS+2 cycles after STORE is entered (14 for NTAPS=4).
- ERR: err=1, op=NOP.
  - lc -> LOAD(0).
  - dr & coeff_ready -> STORE.
  - Otherwise stay.
  - err deasserts the cycle the state leaves ERR.
- lc/dr during STORE..DONE: ignored, except the dr check in STORE.
- Reset mid-operation: immediate return to reset values. coeff_ready clears, so coefficients must be reloaded.
- Unused/illegal state encodings -> IDLE.

Test Plan:
- Reset with n_rst=0 mid-MUL -> all outputs 0, coeff_ready=0, state IDLE on release.
- NTAPS=4: four lc pulses spaced 3 cycles apart -> LOAD_COEFF dest 5,6,7,8; clear only with the first; coeff_ready=1 after the fourth.
- NTAPS=4, coeff_ready=1, dr held 2 cycles, overflow=0 -> op sequence LOAD_SAMPLE(d9), SUB(0,0,0), COPY 1<-2, 2<-3, 3<-4, 4<-9, then MUL 4*5, SUB, MUL 3*6, ADD, MUL 2*7, SUB, MUL 1*8, ADD. processed pulses on the 14th cycle after STORE entry; modwait high throughout.
- dr pulsed for 1 cycle only -> ERR with err=1. A later lc recovers to LOAD(0) and err drops.
- overflow=1 during the second ACC -> ERR next cycle with a processed pulse; no further MUL is issued.
- NTAPS=6, SIGN_MASK=6'b000001: full pass issues SUB only for t=0 and ADD for t=1..5. Coefficient registers are 7..12, scratch is 13, and processed comes 20 cycles after STORE entry.

Source files
------------

// File: rtl/fir_sequencer_param_if.sv
// Handshake and datapath-control bundle between the FIR sequencer and its neighbours.
`timescale 1ns/1ps
interface fir_sequencer_param_if #(
    parameter int REG_W = 4
);
    logic             dr;
    logic             lc;
    logic             overflow;
    logic             cnt_up;
    logic             clear;
    logic             modwait;
    logic [2:0]       op;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] dest;
    logic             err;
    logic             processed;
    logic             coeff_ready;

    modport master (
        input  dr, lc, overflow,
        output cnt_up, clear, modwait, op, src1, src2, dest, err, processed, coeff_ready
    );

    modport slave (
        output dr, lc, overflow,
        input  cnt_up, clear, modwait, op, src1, src2, dest, err, processed, coeff_ready
    );
endinterface

// File: rtl/fir_sequencer_param.sv
// NTAPS-tap FIR sequencer: loads coefficients, then per sample shifts history and
// issues signed multiply-accumulate passes on the shared register-file/ALU datapath.
`timescale 1ns/1ps
module fir_sequencer_param #(
    parameter int               NTAPS     = 4,
    parameter int               REG_W     = 4,
    parameter logic [NTAPS-1:0] SIGN_MASK = 'b0101
) (
    input  logic                clk,
    input  logic                n_rst,
    fir_sequencer_param_if.master bus
);
    localparam int KW = $clog2(NTAPS);
    localparam logic [KW-1:0] LAST = KW'(NTAPS - 1);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_COPY  = 3'b001;
    localparam logic [2:0] OP_LDS   = 3'b010;
    localparam logic [2:0] OP_LDC   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    typedef enum logic [3:0] {
        IDLE, LOAD, WAIT_COEFF, STORE, ZERO, SHIFT, MUL, ACC, DONE, ERR
    } state_t;

    state_t          state, nxt_state;
    logic [KW-1:0]   k, nxt_k;
    logic            modwait_q, processed_q, coeff_ready_q;
    logic            nxt_processed, nxt_coeff_ready;
    logic [2:0]      op;
    logic [REG_W-1:0] src1, src2, dest;
    logic            cnt_up, clear, err;

    function automatic logic [REG_W-1:0] ridx(input int n);
        return REG_W'(n);
    endfunction

    localparam logic [REG_W-1:0] R_ACC = '0;
    localparam logic [REG_W-1:0] R_S   = REG_W'(2 * NTAPS + 1);

    // k doubles as the coefficient index while loading, the shift index and the tap index.
    always_comb begin
        nxt_state       = state;
        nxt_k           = k;
        nxt_processed   = 1'b0;
        nxt_coeff_ready = coeff_ready_q;
        op              = OP_NOP;
        src1            = '0;
        src2            = '0;
        dest            = '0;
        cnt_up          = 1'b0;
        clear           = 1'b0;
        err             = 1'b0;
        case (state)
            IDLE: begin
                if (bus.lc) begin
                    nxt_state = LOAD;
                    nxt_k     = '0;
                end else if (bus.dr) begin
                    nxt_state = coeff_ready_q ? STORE : ERR;
                end
            end
            LOAD: begin
                op   = OP_LDC;
                dest = ridx(NTAPS + 1 + int'(k));
                if (k == '0) begin
                    clear           = 1'b1;
                    nxt_coeff_ready = 1'b0;
                end
                if (k == LAST) begin
                    nxt_state       = IDLE;
                    nxt_coeff_ready = 1'b1;
                end else begin
                    nxt_state = WAIT_COEFF;
                end
            end
            WAIT_COEFF: begin
                if (bus.lc) begin
                    nxt_state = LOAD;
                    nxt_k     = k + KW'(1);
                end
            end
            STORE: begin
                if (bus.dr) begin
                    op        = OP_LDS;
                    dest      = R_S;
                    cnt_up    = 1'b1;
                    nxt_state = ZERO;
                end else begin
                    nxt_state = ERR;
                end
            end
            ZERO: begin
                op        = OP_SUB;
                src1      = R_ACC;
                src2      = R_ACC;
                dest      = R_ACC;
                nxt_state = SHIFT;
                nxt_k     = '0;
            end
            SHIFT: begin
                op = OP_COPY;
                if (k == LAST) begin
                    dest      = ridx(NTAPS);
                    src1      = R_S;
                    nxt_state = MUL;
                    nxt_k     = '0;
                end else begin
                    dest  = ridx(int'(k) + 1);
                    src1  = ridx(int'(k) + 2);
                    nxt_k = k + KW'(1);
                end
            end
            MUL: begin
                op        = OP_MUL;
                src1      = ridx(NTAPS - int'(k));
                src2      = ridx(NTAPS + 1 + int'(k));
                dest      = R_S;
                nxt_state = ACC;
            end
            ACC: begin
                op   = SIGN_MASK[k] ? OP_SUB : OP_ADD;
                src1 = R_ACC;
                src2 = R_S;
                dest = R_ACC;
                if (bus.overflow) begin
                    nxt_state     = ERR;
                    nxt_processed = 1'b1;
                end else if (k != LAST) begin
                    nxt_state = MUL;
                    nxt_k     = k + KW'(1);
                end else begin
                    nxt_state     = DONE;
                    nxt_processed = 1'b1;
                end
            end
            DONE: nxt_state = IDLE;
            ERR: begin
                err = 1'b1;
                if (bus.lc) begin
                    nxt_state = LOAD;
                    nxt_k     = '0;
                end else if (bus.dr && coeff_ready_q) begin
                    nxt_state = STORE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // modwait is registered from the next state so it is high exactly during busy states.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            k             <= '0;
            modwait_q     <= 1'b0;
            processed_q   <= 1'b0;
            coeff_ready_q <= 1'b0;
        end else begin
            state         <= nxt_state;
            k             <= nxt_k;
            modwait_q     <= nxt_state inside {LOAD, STORE, ZERO, SHIFT, MUL, ACC};
            processed_q   <= nxt_processed;
            coeff_ready_q <= nxt_coeff_ready;
        end
    end

    assign bus.op          = op;
    assign bus.src1        = src1;
    assign bus.src2        = src2;
    assign bus.dest        = dest;
    assign bus.cnt_up      = cnt_up;
    assign bus.clear       = clear;
    assign bus.err         = err;
    assign bus.modwait     = modwait_q;
    assign bus.processed   = processed_q;
    assign bus.coeff_ready = coeff_ready_q;
endmodule

// File: tb/tb_fir_sequencer_param.sv
// Bench for fir_sequencer_param: 4-tap vector table and corner sequences, 6-tap scoreboard.
`timescale 1ns/1ps
module tb_fir_sequencer_param;
    localparam logic [2:0] NOP = 3'd0, COPY = 3'd1, LDS = 3'd2, LDC = 3'd3;
    localparam logic [2:0] ADD = 3'd4, SUB = 3'd5, MUL = 3'd6;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic dr4 = 1'b0, lc4 = 1'b0, ov4 = 1'b0;
    logic dr6 = 1'b0, lc6 = 1'b0, ov6 = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic dr, lc, ov;
        logic [2:0] op;
        logic [3:0] s1, s2, d;
        logic cu, cl, mw, er, pr, cr;
    } vec_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] s1, s2, d;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    fir_sequencer_param_if #(.REG_W(4)) bus4 ();
    fir_sequencer_param_if #(.REG_W(4)) bus6 ();

    assign bus4.dr = dr4;
    assign bus4.lc = lc4;
    assign bus4.overflow = ov4;
    assign bus6.dr = dr6;
    assign bus6.lc = lc6;
    assign bus6.overflow = ov6;

    fir_sequencer_param #(.NTAPS(4), .REG_W(4), .SIGN_MASK(4'b0101)) dut4 (
        .clk(clk), .n_rst(n_rst), .bus(bus4.master)
    );
    fir_sequencer_param #(.NTAPS(6), .REG_W(4), .SIGN_MASK(6'b000001)) dut6 (
        .clk(clk), .n_rst(n_rst), .bus(bus6.master)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic dr, lc, ov, input logic [2:0] op,
                                input logic [3:0] s1, s2, d,
                                input logic cu, cl, mw, er, pr, cr);
        vec_t v;
        v.dr = dr; v.lc = lc; v.ov = ov; v.op = op; v.s1 = s1; v.s2 = s2; v.d = d;
        v.cu = cu; v.cl = cl; v.mw = mw; v.er = er; v.pr = pr; v.cr = cr;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic applyStimulus(input logic dr, input logic lc, input logic ov);
        @(negedge clk);
        dr4 = dr;
        lc4 = lc;
        ov4 = ov;
        #1;
    endtask

    task automatic checkOutput(input string nm, input vec_t e);
        cmp({nm, ".op"},    8'(bus4.op),          8'(e.op));
        cmp({nm, ".src1"},  8'(bus4.src1),        8'(e.s1));
        cmp({nm, ".src2"},  8'(bus4.src2),        8'(e.s2));
        cmp({nm, ".dest"},  8'(bus4.dest),        8'(e.d));
        cmp({nm, ".cnt_up"},8'(bus4.cnt_up),      8'(e.cu));
        cmp({nm, ".clear"}, 8'(bus4.clear),       8'(e.cl));
        cmp({nm, ".modw"},  8'(bus4.modwait),     8'(e.mw));
        cmp({nm, ".err"},   8'(bus4.err),         8'(e.er));
        cmp({nm, ".proc"},  8'(bus4.processed),   8'(e.pr));
        cmp({nm, ".crdy"},  8'(bus4.coeff_ready), 8'(e.cr));
    endtask

    // Six-tap side: drive one cycle, then retire any issued datapath op against the scoreboard.
    task automatic step6(input logic dr, input logic lc, input logic ov);
        exp_t e;
        @(negedge clk);
        dr6 = dr;
        lc6 = lc;
        ov6 = ov;
        #1;
        if (bus6.op !== NOP) begin
            if (sb.size() == 0) begin
                cmp("sb6.extra_op", 8'(bus6.op), 8'(NOP));
            end else begin
                e = sb.pop_front();
                cmp("sb6.op",   8'(bus6.op),   8'(e.op));
                cmp("sb6.src1", 8'(bus6.src1), 8'(e.s1));
                cmp("sb6.src2", 8'(bus6.src2), 8'(e.s2));
                cmp("sb6.dest", 8'(bus6.dest), 8'(e.d));
            end
        end
    endtask

    function automatic exp_t ex(input logic [2:0] op, input int s1, input int s2, input int d);
        exp_t e;
        e.op = op; e.s1 = 4'(s1); e.s2 = 4'(s2); e.d = 4'(d);
        return e;
    endfunction

    initial begin
        int n;
        // Coefficient load: lc every 3 cycles, dr poked during WAIT_COEFF.
        tbl.push_back(mk(0,1,0, NOP,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, LDC,0,0,5, 0,1,1,0,0,0));
        tbl.push_back(mk(0,0,0, NOP,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0, NOP,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, LDC,0,0,6, 0,0,1,0,0,0));
        tbl.push_back(mk(1,0,0, NOP,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0, NOP,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, LDC,0,0,7, 0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0, NOP,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0, NOP,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, LDC,0,0,8, 0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0, NOP,0,0,0, 0,0,0,0,0,1));
        // Full sample pass, dr held two cycles.
        tbl.push_back(mk(1,0,0, NOP,0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0, LDS,0,0,9, 1,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, SUB,0,0,0, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, COPY,2,0,1, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, COPY,3,0,2, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, COPY,4,0,3, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, COPY,9,0,4, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, MUL,4,5,9, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, SUB,0,9,0, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, MUL,3,6,9, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, ADD,0,9,0, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, MUL,2,7,9, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, SUB,0,9,0, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, MUL,1,8,9, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, ADD,0,9,0, 0,0,1,0,0,1));
        tbl.push_back(mk(0,0,0, NOP,0,0,0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0, NOP,0,0,0, 0,0,0,0,0,1));

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset", mk(0,0,0, NOP,0,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].dr, tbl[i].lc, tbl[i].ov);
            checkOutput($sformatf("vec%0d", i), tbl[i]);
        end

        // One-cycle dr pulse falls into ERR; lc recovers and forces a reload.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        cmp("drpulse.store_op", 8'(bus4.op), 8'(NOP));
        cmp("drpulse.store_mw", 8'(bus4.modwait), 8'd1);
        applyStimulus(0, 0, 0);
        cmp("drpulse.err", 8'(bus4.err), 8'd1);
        cmp("drpulse.err_mw", 8'(bus4.modwait), 8'd0);
        applyStimulus(0, 1, 0);
        cmp("drpulse.err_hold", 8'(bus4.err), 8'd1);
        applyStimulus(0, 0, 0);
        cmp("recover.err", 8'(bus4.err), 8'd0);
        cmp("recover.op", 8'(bus4.op), 8'(LDC));
        cmp("recover.dest", 8'(bus4.dest), 8'd5);
        cmp("recover.clear", 8'(bus4.clear), 8'd1);
        for (int t = 1; t < 4; t++) begin
            applyStimulus(0, 1, 0);
            applyStimulus(0, 0, 0);
            cmp($sformatf("reload%0d.dest", t), 8'(bus4.dest), 8'(5 + t));
        end
        applyStimulus(0, 0, 0);
        cmp("reload.crdy", 8'(bus4.coeff_ready), 8'd1);

        // Overflow on the second accumulate aborts with a processed pulse.
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        repeat (8) applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        cmp("ovf.acc_op", 8'(bus4.op), 8'(ADD));
        applyStimulus(0, 0, 0);
        cmp("ovf.err", 8'(bus4.err), 8'd1);
        cmp("ovf.proc", 8'(bus4.processed), 8'd1);
        cmp("ovf.op", 8'(bus4.op), 8'(NOP));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0);
            cmp($sformatf("ovf.idle%0d.op", i), 8'(bus4.op), 8'(NOP));
            cmp($sformatf("ovf.idle%0d.proc", i), 8'(bus4.processed), 8'd0);
        end
        applyStimulus(1, 0, 0);
        cmp("errdr.err", 8'(bus4.err), 8'd1);
        applyStimulus(1, 0, 0);
        cmp("errdr.op", 8'(bus4.op), 8'(LDS));
        cmp("errdr.err_low", 8'(bus4.err), 8'd0);

        // Asynchronous reset in the middle of a MUL.
        repeat (5) applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        cmp("premrst.op", 8'(bus4.op), 8'(MUL));
        n_rst = 1'b0;
        #1;
        checkOutput("midrst", mk(0,0,0, NOP,0,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        n_rst = 1'b1;
        applyStimulus(1, 0, 0);
        cmp("postrst.op", 8'(bus4.op), 8'(NOP));
        applyStimulus(0, 0, 0);
        cmp("postrst.err", 8'(bus4.err), 8'd1);
        cmp("postrst.crdy", 8'(bus4.coeff_ready), 8'd0);

        // Six taps: coefficients in R7..R12, scratch R13, only tap 0 subtracts.
        for (int t = 0; t < 6; t++) begin
            sb.push_back(ex(LDC, 0, 0, 7 + t));
            step6(0, 1, 0);
            step6(0, 0, 0);
            step6(0, 0, 0);
        end
        cmp("t6.load_left", 8'(sb.size()), 8'd0);
        cmp("t6.crdy", 8'(bus6.coeff_ready), 8'd1);

        sb.push_back(ex(LDS, 0, 0, 13));
        sb.push_back(ex(SUB, 0, 0, 0));
        for (int s = 0; s < 5; s++) sb.push_back(ex(COPY, s + 2, 0, s + 1));
        sb.push_back(ex(COPY, 13, 0, 6));
        for (int t = 0; t < 6; t++) begin
            sb.push_back(ex(MUL, 6 - t, 7 + t, 13));
            sb.push_back(ex((t == 0) ? SUB : ADD, 0, 13, 0));
        end
        step6(1, 0, 0);
        step6(1, 0, 0);
        n = 0;
        while (n < 40) begin
            step6(0, 0, 0);
            n++;
            if (bus6.processed === 1'b1) break;
        end
        cmp("t6.latency", 8'(n), 8'd20);
        cmp("t6.pass_left", 8'(sb.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
